cache_memory: RTL and testbench
===============================

// Module: cache_memory
// PURPOSE
//  Data/tag store of a 64-line direct-mapped, write-back, write-allocate cache.
//  Sits under the cache controller FSM, which drives read/write/refill strobes.
//  Reports hit and dirty status; serves 32-bit word reads and writes.
//  Exposes the indexed line's data block for eviction to main memory.
// PARAMETERS
//  BLOCK_SIZE  128  line data width in bits (4 x 32-bit words)
//  TAG_W       24   tag width
//  INDEX_W     6    index width (2**INDEX_W = 64 lines)
//  OFFSET_W    2    word-offset width
// PORTS
//  clk              in   1           system clock, all state updates on rising edge
//  rst              in   1           asynchronous active-high reset
//  tag              in   TAG_W       request tag
//  index            in   INDEX_W     line select
//  blk_offset       in   OFFSET_W    word select within line
//  req_type         in   1           0 = read request, 1 = write request
//  read_en_cache    in   1           read strobe
//  write_en_cache   in   1           write strobe (word write, or line fill with refill)
//  refill           in   1           with write_en_cache: load whole line from memory
//  data_in_mem      in   BLOCK_SIZE  refill block from main memory
//  data_in          in   32          CPU write word
//  dirty_block_out  out  BLOCK_SIZE  data field of line[index] (eviction data)
//  hit              out  1           line[index] valid and its tag == tag
//  data_out         out  32          registered read word
//  dirty_bit        out  1           dirty flag of line[index]
// BEHAVIOUR
//  - Line format (154 b): [153:26] data, [25:2] tag, [1] dirty, [0] valid.
//  - Word w of a line is at data[32*w +: 32]; word 0 is at line bits [57:26].
//  - hit, dirty_bit and dirty_block_out are combinational from line[index], no latency.
//  - Read: read_en_cache & hit at a rising edge -> data_out <= word[blk_offset].
//    Otherwise data_out holds its value.
//  - Word write: write_en_cache & req_type & ~refill & hit at a rising edge:
//    - word[blk_offset] <= data_in;
//    - dirty <= 1; tag, valid and the other words are unchanged.
//  - Write miss (write_en_cache & ~refill & ~hit): no state change.
//  - Refill: write_en_cache & refill at a rising edge:
//    - line[index] <= {data_in_mem, tag, dirty=0, valid=1};
//    - refill has priority over a word write in the same cycle.
//  - read_en_cache and write_en_cache both high: perform both; read returns the pre-write word.
//  - Reset (async, any time, including mid-operation):
//    - all valid and dirty bits cleared; data_out = 0;
//    - data and tag arrays are not cleared;
//    - hit = 0 and dirty_bit = 0 while in or after reset until a refill.
//  - Memory is also writable via hierarchical preload (cache[i]) for test.
//  - The eviction decision belongs to the controller.
//    dirty_block_out is valid whenever index addresses a dirty line.
// STRUCTURE
//  - Shared package cache_pkg:
//    - BLOCK_SIZE, TAG_W, INDEX_W, OFFSET_W, LINE_W = BLOCK_SIZE + TAG_W + 2;
//    - packed struct cache_line_t {data, tag, dirty, valid}.
//  - Storage: single array cache[0:63] of LINE_W bits, named cache so benches can preload it.
//  - No sub-module; word mux/merge is inline logic.
// TESTING
//  1 Read hit:
//    - preload line0 with tag 0xABCDE0, valid=1, dirty=0; read idx0 off3;
//    - expect hit=1, dirty_bit=0, data_out = line0 data[127:96] after the edge.
//  2 Write hit:
//    - line1 tag 0x000ABC valid; write idx1 off3 data_in=0xCAFEBABE;
//    - expect hit=1; after the edge dirty_bit=1, word3=0xCAFEBABE, other words unchanged.
//  3 Read miss, clean:
//    - idx2 tag mismatch -> hit=0, dirty_bit=0;
//    - refill with 0xCAFEBABEF0F0AAAA1C78F0F0F0F0F0F0 -> hit=1, dirty_bit=0, line tag = request tag.
//  4 Read miss, dirty:
//    - line3 valid, dirty=1, tag differs -> hit=0, dirty_bit=1;
//    - dirty_block_out = line3 data[127:0] exactly.
//  5 Write miss allocate:
//    - idx4 miss, word write -> no change;
//    - refill -> dirty=0;
//    - write off3 0x4AFEBABE -> hit=1, dirty=1, word3 updated.
//  6 Reset:
//    - after traffic, pulse rst between edges -> hit=0, dirty_bit=0, data_out=0 immediately;
//    - compulsory miss at idx7, then refill -> hit=1.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared constants, line layout and word select/merge helpers for the
// direct-mapped cache data/tag store.
package cache_pkg;

    localparam int BLOCK_SIZE = 128;
    localparam int TAG_W      = 24;
    localparam int INDEX_W    = 6;
    localparam int OFFSET_W   = 2;
    localparam int WORD_W     = 32;
    localparam int NUM_LINES  = 2 ** INDEX_W;
    localparam int LINE_W     = BLOCK_SIZE + TAG_W + 2;

    typedef struct packed {
        logic [BLOCK_SIZE-1:0] data;
        logic [TAG_W-1:0]      tag;
        logic                  dirty;
        logic                  valid;
    } cache_line_t;

    function automatic logic [WORD_W-1:0] get_word(input logic [BLOCK_SIZE-1:0] blk,
                                                   input logic [OFFSET_W-1:0]   off);
        return blk[WORD_W*off +: WORD_W];
    endfunction

    function automatic logic [BLOCK_SIZE-1:0] put_word(input logic [BLOCK_SIZE-1:0] blk,
                                                       input logic [OFFSET_W-1:0]   off,
                                                       input logic [WORD_W-1:0]     word);
        logic [BLOCK_SIZE-1:0] res;
        res = blk;
        res[WORD_W*off +: WORD_W] = word;
        return res;
    endfunction

endpackage

// File: rtl/cache_memory.sv
// Data/tag store of a 64-line direct-mapped write-back cache: hit/dirty
// lookup, registered word reads, word writes and whole-line refills.
module cache_memory
    import cache_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [TAG_W-1:0]      tag,
    input  logic [INDEX_W-1:0]    index,
    input  logic [OFFSET_W-1:0]   blk_offset,
    input  logic                  req_type,
    input  logic                  read_en_cache,
    input  logic                  write_en_cache,
    input  logic                  refill,
    input  logic [BLOCK_SIZE-1:0] data_in_mem,
    input  logic [WORD_W-1:0]     data_in,
    output logic [BLOCK_SIZE-1:0] dirty_block_out,
    output logic                  hit,
    output logic [WORD_W-1:0]     data_out,
    output logic                  dirty_bit
);

    logic [LINE_W-1:0] cache [0:NUM_LINES-1];

    cache_line_t line_s;
    cache_line_t wr_line_s;
    logic        hit_s;
    logic        rd_s;
    logic        word_wr_s;
    logic        refill_wr_s;

    // Decode the addressed line and the strobes acting on it this cycle.
    always_comb begin
        line_s         = cache[index];
        hit_s          = line_s.valid && (line_s.tag == tag);
        rd_s           = read_en_cache && hit_s;
        refill_wr_s    = write_en_cache && refill;
        word_wr_s      = write_en_cache && req_type && !refill && hit_s;
        wr_line_s      = line_s;
        wr_line_s.data = put_word(line_s.data, blk_offset, data_in);
        wr_line_s.dirty = 1'b1;
    end

    assign hit             = hit_s;
    assign dirty_bit       = line_s.dirty;
    assign dirty_block_out = line_s.data;

    // Line storage and read register; reset clears only status bits, data and tags survive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                cache[i][1:0] <= 2'b00;
            end
            data_out <= {WORD_W{1'b0}};
        end else begin
            if (rd_s) begin
                data_out <= get_word(line_s.data, blk_offset);
            end
            if (refill_wr_s) begin
                cache[index] <= {data_in_mem, tag, 1'b0, 1'b1};
            end else if (word_wr_s) begin
                cache[index] <= wr_line_s;
            end
        end
    end

endmodule

// File: tb/tb_cache_memory.sv
// Directed scoreboard bench for cache_memory: stimulus queues expected
// outputs, a negedge monitor pops and compares them.
module tb_cache_memory;
    import cache_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [TAG_W-1:0]      tag = '0;
    logic [INDEX_W-1:0]    index = '0;
    logic [OFFSET_W-1:0]   blk_offset = '0;
    logic                  req_type = 1'b0;
    logic                  read_en_cache = 1'b0;
    logic                  write_en_cache = 1'b0;
    logic                  refill = 1'b0;
    logic [BLOCK_SIZE-1:0] data_in_mem = '0;
    logic [WORD_W-1:0]     data_in = '0;
    logic [BLOCK_SIZE-1:0] dirty_block_out;
    logic                  hit;
    logic [WORD_W-1:0]     data_out;
    logic                  dirty_bit;

    cache_memory dut (
        .clk(clk), .rst(rst), .tag(tag), .index(index), .blk_offset(blk_offset),
        .req_type(req_type), .read_en_cache(read_en_cache),
        .write_en_cache(write_en_cache), .refill(refill),
        .data_in_mem(data_in_mem), .data_in(data_in),
        .dirty_block_out(dirty_block_out), .hit(hit), .data_out(data_out),
        .dirty_bit(dirty_bit)
    );

    always #5 clk = ~clk;

    typedef struct {
        int             sig;   // 0 hit, 1 dirty_bit, 2 data_out, 3 dirty_block_out
        logic [127:0]   val;
        string          name;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic void push(input int sig, input logic [127:0] val, input string name);
        exp_t e;
        e.sig = sig; e.val = val; e.name = name;
        exp_q.push_back(e);
    endfunction

    // Monitor: compare every queued expectation against the DUT at the falling edge.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            logic [127:0] act;
            e = exp_q.pop_front();
            case (e.sig)
                0: act = {127'd0, hit};
                1: act = {127'd0, dirty_bit};
                2: act = {96'd0, data_out};
                default: act = dirty_block_out;
            endcase
            n_cmp++;
            if (act !== e.val) begin
                n_err++;
                $display("FAIL %s: actual=%h required=%h", e.name, act, e.val);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        read_en_cache = 1'b0; write_en_cache = 1'b0; refill = 1'b0; req_type = 1'b0;
    endtask

    task automatic addr(input logic [TAG_W-1:0] t, input logic [INDEX_W-1:0] i,
                        input logic [OFFSET_W-1:0] o);
        tag = t; index = i; blk_offset = o;
    endtask

    localparam logic [127:0] D0 = 128'h11112222_33334444_55556666_77778888;
    localparam logic [127:0] D1 = 128'hAAAA0000_BBBB1111_CCCC2222_DDDD3333;
    localparam logic [127:0] D2 = 128'h99990000_88881111_77772222_66663333;
    localparam logic [127:0] R2 = 128'hCAFEBABE_F0F0AAAA_1C78F0F0_F0F0F0F0;
    localparam logic [127:0] D3 = 128'hDEADBEEF_0BADF00D_FEEDFACE_C0FFEE00;
    localparam logic [127:0] M4 = 128'h01020304_05060708_090A0B0C_0D0E0F10;
    localparam logic [127:0] M5 = 128'h5A5A5A5A_A5A5A5A5_3C3C3C3C_C3C3C3C3;
    localparam logic [127:0] M7 = 128'h77770000_77771111_77772222_77773333;

    initial begin
        step();
        step();
        rst = 1'b0;
        dut.cache[0] = {D0, 24'hABCDE0, 1'b0, 1'b1};
        dut.cache[1] = {D1, 24'h000ABC, 1'b0, 1'b1};
        dut.cache[2] = {D2, 24'h111111, 1'b0, 1'b1};
        dut.cache[3] = {D3, 24'h333333, 1'b1, 1'b1};
        dut.cache[4] = {128'd0, 24'h000000, 1'b0, 1'b0};
        push(2, 128'd0, "reset_data_out");
        step();

        // 1: read hit
        addr(24'hABCDE0, 6'd0, 2'd3); read_en_cache = 1'b1;
        push(0, 128'd1, "rd_hit"); push(1, 128'd0, "rd_hit_clean");
        step(); idle();
        push(2, {96'd0, 32'h11112222}, "rd_word3");
        step();
        // read miss leaves data_out unchanged
        addr(24'hABCDE1, 6'd0, 2'd0); read_en_cache = 1'b1;
        push(0, 128'd0, "rd_miss_hit");
        step(); idle();
        push(2, {96'd0, 32'h11112222}, "rd_miss_hold");
        step();

        // 2: write hit
        addr(24'h000ABC, 6'd1, 2'd3); req_type = 1'b1; write_en_cache = 1'b1;
        data_in = 32'hCAFEBABE;
        push(0, 128'd1, "wr_hit"); push(1, 128'd0, "wr_pre_dirty");
        step(); idle();
        push(1, 128'd1, "wr_post_dirty"); push(0, 128'd1, "wr_post_hit");
        push(3, 128'hCAFEBABE_BBBB1111_CCCC2222_DDDD3333, "wr_block");
        step();
        // simultaneous read and write: read returns the pre-write word
        addr(24'h000ABC, 6'd1, 2'd3); req_type = 1'b1; write_en_cache = 1'b1;
        read_en_cache = 1'b1; data_in = 32'h12345678;
        step(); idle();
        push(2, {96'd0, 32'hCAFEBABE}, "rdwr_old_word");
        push(3, 128'h12345678_BBBB1111_CCCC2222_DDDD3333, "rdwr_block");
        step();

        // 3: read miss, clean line, then refill
        addr(24'h222222, 6'd2, 2'd0); read_en_cache = 1'b1;
        push(0, 128'd0, "miss_clean_hit"); push(1, 128'd0, "miss_clean_dirty");
        step(); idle();
        write_en_cache = 1'b1; refill = 1'b1; data_in_mem = R2;
        step(); idle();
        push(0, 128'd1, "refill_hit"); push(1, 128'd0, "refill_dirty");
        push(3, R2, "refill_block");
        step();
        addr(24'h111111, 6'd2, 2'd0);
        push(0, 128'd0, "refill_old_tag");
        step();

        // 4: read miss on a dirty line exposes eviction data
        addr(24'h444444, 6'd3, 2'd1); read_en_cache = 1'b1;
        push(0, 128'd0, "miss_dirty_hit"); push(1, 128'd1, "miss_dirty_dirty");
        push(3, D3, "evict_block");
        step(); idle();
        step();

        // 5: write miss, allocate, write
        addr(24'h555555, 6'd4, 2'd3); req_type = 1'b1; write_en_cache = 1'b1;
        data_in = 32'h4AFEBABE;
        push(0, 128'd0, "wmiss_hit");
        step(); idle();
        push(0, 128'd0, "wmiss_nochg_hit"); push(1, 128'd0, "wmiss_nochg_dirty");
        push(3, 128'd0, "wmiss_nochg_block");
        step();
        write_en_cache = 1'b1; refill = 1'b1; data_in_mem = M4;
        step(); idle();
        push(0, 128'd1, "alloc_hit"); push(1, 128'd0, "alloc_dirty");
        step();
        req_type = 1'b1; write_en_cache = 1'b1; data_in = 32'h4AFEBABE;
        step(); idle();
        push(0, 128'd1, "alloc_wr_hit"); push(1, 128'd1, "alloc_wr_dirty");
        push(3, 128'h4AFEBABE_05060708_090A0B0C_0D0E0F10, "alloc_wr_block");
        step();
        // refill wins over a word write in the same cycle
        req_type = 1'b1; write_en_cache = 1'b1; refill = 1'b1;
        data_in = 32'hFFFFFFFF; data_in_mem = M5;
        step(); idle();
        push(1, 128'd0, "prio_dirty"); push(3, M5, "prio_block");
        step();

        // 6: asynchronous reset pulse between edges
        addr(24'h000ABC, 6'd1, 2'd0);
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        push(0, 128'd0, "rst_hit"); push(1, 128'd0, "rst_dirty");
        push(2, 128'd0, "rst_data_out");
        step();
        addr(24'h777777, 6'd7, 2'd2); read_en_cache = 1'b1;
        push(0, 128'd0, "cold_miss_hit");
        step(); idle();
        push(2, 128'd0, "cold_miss_hold");
        write_en_cache = 1'b1; refill = 1'b1; data_in_mem = M7;
        step(); idle();
        push(0, 128'd1, "cold_refill_hit"); push(1, 128'd0, "cold_refill_dirty");
        read_en_cache = 1'b1;
        step(); idle();
        push(2, {96'd0, 32'h77771111}, "cold_refill_read");
        step();
        step();

        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
